// File: rtl/snoop_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// snoop_bus_arbiter_if
//
// Bundles the request, snoop and completion signals exchanged between the two
// CPUs and the coherence bus arbiter.
//
// Parameter:
//   ADDR_W           block address width on the bus
//
// Signals (direction seen from the arbiter / slave modport):
//   req_0/1          in   miss request, held until done_x
//   wr_0/1           in   1 = write miss, 0 = read miss
//   addr_0/1         in   miss block address
//   ack_0/1          in   peer search complete
//   found_0/1        in   searched block present, qualified by ack_x
//   grant_0/1        out  bus owned by CPU0/CPU1
//   bus_addr         out  latched owner address while granted, else 0
//   search_0/1       out  search request into that CPU's cache
//   datasel_0/1      out  owner takes line from peer cache (pulse)
//   inv_0/1          out  invalidate bus_addr in that CPU's cache (pulse)
//   done_0/1         out  transaction complete (pulse)
// -----------------------------------------------------------------------------
interface snoop_bus_arbiter_if #(
    parameter int ADDR_W = 11
);
    logic              req_0;
    logic              req_1;
    logic              wr_0;
    logic              wr_1;
    logic [ADDR_W-1:0] addr_0;
    logic [ADDR_W-1:0] addr_1;
    logic              ack_0;
    logic              ack_1;
    logic              found_0;
    logic              found_1;

    logic              grant_0;
    logic              grant_1;
    logic [ADDR_W-1:0] bus_addr;
    logic              search_0;
    logic              search_1;
    logic              datasel_0;
    logic              datasel_1;
    logic              inv_0;
    logic              inv_1;
    logic              done_0;
    logic              done_1;

    // CPU / cache side
    modport master (
        output req_0, req_1, wr_0, wr_1, addr_0, addr_1,
        output ack_0, ack_1, found_0, found_1,
        input  grant_0, grant_1, bus_addr, search_0, search_1,
        input  datasel_0, datasel_1, inv_0, inv_1, done_0, done_1
    );

    // Arbiter side
    modport slave (
        input  req_0, req_1, wr_0, wr_1, addr_0, addr_1,
        input  ack_0, ack_1, found_0, found_1,
        output grant_0, grant_1, bus_addr, search_0, search_1,
        output datasel_0, datasel_1, inv_0, inv_1, done_0, done_1
    );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// -----------------------------------------------------------------------------
// snoop_bus_arbiter
//
// Round-robin arbiter and sequencer for the shared coherence bus between CPU0
// and CPU1. One miss is served at a time: the owner is granted, the peer cache
// is searched, and on a hit either a cache-to-cache data select (read miss) or
// a peer invalidate (write miss) is pulsed before done is returned.
//
// Sequence: IDLE -> SNOOP (until peer ack) -> RESP (1 cycle) -> DONE (1 cycle)
//
// Parameters:
//   ADDR_W    block address width
//   TIMEOUT   snoop-ack wait limit in SNOOP cycles (timeout build only)
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   bus       snoop_bus_arbiter_if.slave (requests, snoop, completion)
//   busy      FSM not IDLE (registered)
//   err       sticky snoop-timeout flag
//
// Build option:
//   SNOOP_TIMEOUT_EN  when defined, a SNOOP cycle counter forces a not-found
//                     response after TIMEOUT cycles without a peer ack and
//                     sets err. When undefined, SNOOP waits forever and err
//                     is tied low.
//
// Every output comes straight from a register; there is no combinational
// input-to-output path.
// -----------------------------------------------------------------------------
module snoop_bus_arbiter #(
    parameter int ADDR_W  = 11,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    snoop_bus_arbiter_if.slave bus,
    output logic               busy,
    output logic               err
);

    if (TIMEOUT < 1) begin : g_timeout_range
        $error("snoop_bus_arbiter: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNOOP = 2'd1,
        RESP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic              owner;       // 0 = CPU0 owns the bus, 1 = CPU1
    logic              rr;          // CPU favoured on a tie
    logic              wr_q;        // latched write/read kind of the owner miss
    logic              just_done;   // high in the IDLE cycle right after DONE
    logic [ADDR_W-1:0] bus_addr_q;
    logic              grant_0_q;
    logic              grant_1_q;
    logic              search_0_q;
    logic              search_1_q;
    logic              datasel_0_q;
    logic              datasel_1_q;
    logic              inv_0_q;
    logic              inv_1_q;
    logic              done_0_q;
    logic              done_1_q;
    logic              busy_q;

`ifdef SNOOP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] snoop_cnt;
    logic             err_q;
`endif

    // The CPU served last still has req high during the IDLE cycle right after
    // DONE only if it failed to drop it; masking it keeps a stale request from
    // being re-granted.
    logic req_0_ok;
    logic req_1_ok;
    logic pick;
    logic ack_peer;
    logic found_peer;

    assign req_0_ok   = bus.req_0 && !(just_done && !owner);
    assign req_1_ok   = bus.req_1 && !(just_done &&  owner);
    assign pick       = (req_0_ok && req_1_ok) ? rr : req_1_ok;
    assign ack_peer   = owner ? bus.ack_0   : bus.ack_1;
    assign found_peer = owner ? bus.found_0 : bus.found_1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= 1'b0;
            rr          <= 1'b0;
            wr_q        <= 1'b0;
            just_done   <= 1'b0;
            bus_addr_q  <= '0;
            grant_0_q   <= 1'b0;
            grant_1_q   <= 1'b0;
            search_0_q  <= 1'b0;
            search_1_q  <= 1'b0;
            datasel_0_q <= 1'b0;
            datasel_1_q <= 1'b0;
            inv_0_q     <= 1'b0;
            inv_1_q     <= 1'b0;
            done_0_q    <= 1'b0;
            done_1_q    <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SNOOP_TIMEOUT_EN
            snoop_cnt   <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            // Pulse outputs last exactly one cycle unless re-armed below.
            datasel_0_q <= 1'b0;
            datasel_1_q <= 1'b0;
            inv_0_q     <= 1'b0;
            inv_1_q     <= 1'b0;
            done_0_q    <= 1'b0;
            done_1_q    <= 1'b0;
            just_done   <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_0_ok || req_1_ok) begin
                        owner      <= pick;
                        wr_q       <= pick ? bus.wr_1   : bus.wr_0;
                        bus_addr_q <= pick ? bus.addr_1 : bus.addr_0;
                        grant_0_q  <= !pick;
                        grant_1_q  <=  pick;
                        // The peer is searched, never the owner.
                        search_0_q <=  pick;
                        search_1_q <= !pick;
                        busy_q     <= 1'b1;
                        state      <= SNOOP;
`ifdef SNOOP_TIMEOUT_EN
                        snoop_cnt  <= '0;
`endif
                    end
                end

                SNOOP: begin
                    if (ack_peer) begin
                        search_0_q  <= 1'b0;
                        search_1_q  <= 1'b0;
                        // Response pulses are armed here so they appear in RESP.
                        datasel_0_q <= found_peer && !wr_q && !owner;
                        datasel_1_q <= found_peer && !wr_q &&  owner;
                        inv_0_q     <= found_peer &&  wr_q &&  owner;
                        inv_1_q     <= found_peer &&  wr_q && !owner;
                        state       <= RESP;
                    end
`ifdef SNOOP_TIMEOUT_EN
                    // An ack in the expiry cycle wins over the timeout.
                    else if (snoop_cnt == CNT_LAST) begin
                        search_0_q <= 1'b0;
                        search_1_q <= 1'b0;
                        err_q      <= 1'b1;
                        state      <= RESP;
                    end else begin
                        snoop_cnt <= snoop_cnt + 1'b1;
                    end
`endif
                end

                RESP: begin
                    done_0_q <= !owner;
                    done_1_q <=  owner;
                    state    <= DONE;
                end

                DONE: begin
                    grant_0_q  <= 1'b0;
                    grant_1_q  <= 1'b0;
                    bus_addr_q <= '0;
                    busy_q     <= 1'b0;
                    rr         <= !owner;
                    just_done  <= 1'b1;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant_0   = grant_0_q;
    assign bus.grant_1   = grant_1_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.search_0  = search_0_q;
    assign bus.search_1  = search_1_q;
    assign bus.datasel_0 = datasel_0_q;
    assign bus.datasel_1 = datasel_1_q;
    assign bus.inv_0     = inv_0_q;
    assign bus.inv_1     = inv_1_q;
    assign bus.done_0    = done_0_q;
    assign bus.done_1    = done_1_q;
    assign busy          = busy_q;

`ifdef SNOOP_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_snoop_bus_arbiter
//
// Directed bench for snoop_bus_arbiter. A transaction-level model tracks the
// grant/ack/response timeline of each transaction and predicts every output
// on every cycle; directed sequences add literal expectations at key cycles.
// Inputs change 1 time unit after the rising edge; outputs are read at the
// falling edge or 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_snoop_bus_arbiter;
    localparam int ADDR_W  = 11;
    localparam int TIMEOUT = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic err;

    snoop_bus_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    snoop_bus_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- peer cache responder settings ----------------
    int dly0 = 0;            // CPU0 acks in the dly0-th cycle of search_0 (0 = never)
    int dly1 = 0;
    bit fnd0 = 0;            // found value returned with the ack
    bit fnd1 = 0;
    bit noise_ack = 0;       // ack level driven while not being searched
    bit noise_found = 0;     // found level driven outside the ack cycle
    bit hold_req = 0;        // CPU0 keeps req one cycle past done
    int s0 = 0;
    int s1 = 0;

    task automatic respond();
        if (bus.search_0) s0 = s0 + 1; else s0 = 0;
        if (bus.search_1) s1 = s1 + 1; else s1 = 0;
        bus.ack_0   = bus.search_0 ? (s0 == dly0) : noise_ack;
        bus.ack_1   = bus.search_1 ? (s1 == dly1) : noise_ack;
        bus.found_0 = (bus.search_0 && s0 == dly0) ? fnd0 : noise_found;
        bus.found_1 = (bus.search_1 && s1 == dly1) ? fnd1 : noise_found;
    endtask

    // Advance one cycle; requesters drop req on the edge where done is high.
    task automatic step();
        bit d0;
        bit d1;
        @(negedge clk);
        d0 = bus.done_0;
        d1 = bus.done_1;
        @(posedge clk);
        #1;
        if (d0 && !hold_req) bus.req_0 = 1'b0;
        if (d1) bus.req_1 = 1'b0;
        respond();
    endtask

    // ---------------- transaction-level model ----------------
    int                m_cyc = 0;
    bit                m_tx = 0;      // a transaction is in flight
    bit                m_own = 0;
    bit                m_wr = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    int                m_g = 0;       // first granted cycle
    int                m_a = -1;      // cycle the search completed (ack or timeout)
    bit                m_found = 0;
    bit                m_rr = 0;
    int                m_mask_cyc = -1;
    bit                m_mask_cpu = 0;
    bit                m_err = 0;
    logic [11:0]       exp_v;
    logic [11:0]       act_v;
    logic [ADDR_W-1:0] exp_a;
    bit                e_g, e_s, e_p, e_d, r0, r1;

    always @(negedge clk) begin
        m_cyc++;
        if (!rst_n) begin
            m_tx = 0; m_rr = 0; m_err = 0; m_mask_cyc = -1;
            exp_v = '0;
            exp_a = '0;
        end else begin
            e_g = m_tx && m_cyc >= m_g && (m_a < 0 || m_cyc <= m_a + 2);
            e_s = m_tx && m_cyc >= m_g && (m_a < 0 || m_cyc <= m_a);
            e_p = m_tx && m_a >= 0 && m_cyc == m_a + 1 && m_found;
            e_d = m_tx && m_a >= 0 && m_cyc == m_a + 2;
            exp_v = {e_g && !m_own, e_g && m_own,
                     e_s && m_own,  e_s && !m_own,
                     e_p && !m_wr && !m_own, e_p && !m_wr && m_own,
                     e_p && m_wr && m_own,   e_p && m_wr && !m_own,
                     e_d && !m_own, e_d && m_own,
                     e_g, m_err};
            exp_a = e_g ? m_addr : '0;
        end
        act_v = {bus.grant_0, bus.grant_1, bus.search_0, bus.search_1,
                 bus.datasel_0, bus.datasel_1, bus.inv_0, bus.inv_1,
                 bus.done_0, bus.done_1, busy, err};
        chk("model_outputs", 32'(act_v), 32'(exp_v));
        chk("model_bus_addr", 32'(bus.bus_addr), 32'(exp_a));

        if (rst_n) begin
            if (!m_tx) begin
                r0 = bus.req_0 && !(m_cyc == m_mask_cyc && !m_mask_cpu);
                r1 = bus.req_1 && !(m_cyc == m_mask_cyc &&  m_mask_cpu);
                if (r0 || r1) begin
                    m_own  = (r0 && r1) ? m_rr : r1;
                    m_wr   = m_own ? bus.wr_1 : bus.wr_0;
                    m_addr = m_own ? bus.addr_1 : bus.addr_0;
                    m_g    = m_cyc + 1;
                    m_a    = -1;
                    m_tx   = 1;
                end
            end else if (m_cyc >= m_g) begin
                if (m_a < 0) begin
                    if (m_own ? bus.ack_0 : bus.ack_1) begin
                        m_a     = m_cyc;
                        m_found = m_own ? bus.found_0 : bus.found_1;
                    end
`ifdef SNOOP_TIMEOUT_EN
                    else if (m_cyc - m_g + 1 == TIMEOUT) begin
                        m_a     = m_cyc;
                        m_found = 0;
                        m_err   = 1;
                    end
`endif
                end
                if (m_a >= 0 && m_cyc == m_a + 2) begin
                    m_tx       = 0;
                    m_rr       = !m_own;
                    m_mask_cyc = m_cyc + 1;
                    m_mask_cpu = m_own;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int scount;
        bus.req_0 = 0; bus.req_1 = 0; bus.wr_0 = 0; bus.wr_1 = 0;
        bus.addr_0 = '0; bus.addr_1 = '0;
        bus.ack_0 = 0; bus.ack_1 = 0; bus.found_0 = 0; bus.found_1 = 0;

        // Reset
        rst_n = 0;
        repeat (2) step();
        chk("reset_busy", busy, 0);
        chk("reset_grants", {bus.grant_0, bus.grant_1}, 0);
        chk("reset_err", err, 0);
        rst_n = 1;
        step();

        // CPU0 read miss 0x2A5, CPU1 acks in cycle 2 with found
        bus.req_0 = 1; bus.wr_0 = 0; bus.addr_0 = 11'h2A5; dly1 = 2; fnd1 = 1;
        step();  // cycle 1
        chk("t1_grant0_c1", bus.grant_0, 1);
        chk("t1_search1_c1", bus.search_1, 1);
        chk("t1_bus_addr_c1", bus.bus_addr, 11'h2A5);
        step();  // cycle 2
        chk("t1_search1_c2", bus.search_1, 1);
        step();  // cycle 3
        chk("t1_datasel0_c3", bus.datasel_0, 1);
        chk("t1_search1_c3", bus.search_1, 0);
        chk("t1_inv1_c3", bus.inv_1, 0);
        step();  // cycle 4
        chk("t1_done0_c4", bus.done_0, 1);
        chk("t1_grant0_c4", bus.grant_0, 1);
        chk("t1_datasel0_c4", bus.datasel_0, 0);
        step();  // cycle 5
        chk("t1_grant0_c5", bus.grant_0, 0);
        chk("t1_busy_c5", busy, 0);

        // CPU1 write miss 0x013, CPU0 acks in cycle 1 with found
        bus.req_1 = 1; bus.wr_1 = 1; bus.addr_1 = 11'h013; dly0 = 1; fnd0 = 1;
        step();  // cycle 1
        chk("t2_grant1_c1", bus.grant_1, 1);
        chk("t2_search0_c1", bus.search_0, 1);
        step();  // cycle 2
        chk("t2_inv0_c2", bus.inv_0, 1);
        chk("t2_datasel1_c2", bus.datasel_1, 0);
        step();  // cycle 3
        chk("t2_done1_c3", bus.done_1, 1);
        step();
        step();

        // Simultaneous pairs: CPU0, then CPU1 after one IDLE cycle, then CPU0
        bus.wr_0 = 0; bus.wr_1 = 0; bus.addr_0 = 11'h100; bus.addr_1 = 11'h200;
        dly0 = 1; dly1 = 1; fnd0 = 1; fnd1 = 1;
        bus.req_0 = 1; bus.req_1 = 1;
        step();  // cycle 1
        chk("t3_grant_c1", {bus.grant_0, bus.grant_1}, 2'b10);
        step(); step();  // cycle 3
        chk("t3_done0_c3", bus.done_0, 1);
        step();  // cycle 4
        chk("t3_idle_grants_c4", {bus.grant_0, bus.grant_1}, 2'b00);
        step();  // cycle 5
        chk("t3_grant_c5", {bus.grant_0, bus.grant_1}, 2'b01);
        repeat (4) step();  // cycle 9
        bus.req_0 = 1; bus.req_1 = 1;
        step();  // cycle 10
        chk("t3_grant_c10", {bus.grant_0, bus.grant_1}, 2'b10);
        repeat (7) step();
        chk("t3_busy_end", busy, 0);

        // Not-found read with found noise outside the ack cycle
        bus.req_0 = 1; bus.wr_0 = 0; bus.addr_0 = 11'h7FF; dly1 = 3; fnd1 = 0; noise_found = 1;
        step(); step();  // cycle 2
        chk("t4_search1_c2", bus.search_1, 1);
        step(); step();  // cycle 4
        chk("t4_no_pulse_c4", {bus.datasel_0, bus.inv_1}, 2'b00);
        step();  // cycle 5
        chk("t4_done0_c5", bus.done_0, 1);
        step();

        // Owner ack noise, address/kind change after grant, early req drop
        noise_ack = 1;
        bus.req_1 = 1; bus.wr_1 = 0; bus.addr_1 = 11'h155; dly0 = 2; fnd0 = 1;
        step();  // cycle 1
        bus.addr_1 = 11'h0AA; bus.wr_1 = 1;
        chk("t5_search0_c1", bus.search_0, 1);
        step();  // cycle 2
        bus.req_1 = 0;
        chk("t5_bus_addr_c2", bus.bus_addr, 11'h155);
        step();  // cycle 3
        chk("t5_datasel1_c3", {bus.datasel_1, bus.inv_0}, 2'b10);
        step();  // cycle 4
        chk("t5_done1_c4", bus.done_1, 1);
        step();
        noise_ack = 0; noise_found = 0;
        step();

        // Stale request from the CPU just served is not re-granted
        hold_req = 1;
        bus.req_0 = 1; bus.wr_0 = 0; bus.addr_0 = 11'h0F0; dly1 = 1; fnd1 = 1;
        repeat (4) step();  // cycle 4, req_0 still high
        step();  // cycle 5
        bus.req_0 = 0; hold_req = 0;
        chk("t6_grant0_c5", bus.grant_0, 0);
        chk("t6_busy_c5", busy, 0);
        step();
        chk("t6_busy_c6", busy, 0);

        // Reset in SNOOP with grant_1 high, then a tie goes to CPU0
        bus.req_1 = 1; bus.wr_1 = 0; bus.addr_1 = 11'h321; dly0 = 0;
        step();  // cycle 1
        chk("t7_grant1_c1", bus.grant_1, 1);
        step();  // cycle 2
        rst_n = 0;
        #1;
        chk("t7_rst_grant", {bus.grant_0, bus.grant_1}, 0);
        chk("t7_rst_search_busy", {bus.search_0, busy}, 0);
        chk("t7_rst_bus_addr", bus.bus_addr, 0);
        bus.req_0 = 1; bus.addr_0 = 11'h444; dly0 = 1; dly1 = 1;
        step();  // cycle 3
        rst_n = 1;
        step();  // cycle 4
        chk("t7_tie_after_reset", {bus.grant_0, bus.grant_1}, 2'b10);
        repeat (7) step();
        chk("t7_busy_end", busy, 0);

`ifdef SNOOP_TIMEOUT_EN
        // Ack in the expiry cycle is honoured
        bus.req_0 = 1; bus.wr_0 = 0; bus.addr_0 = 11'h066; dly1 = TIMEOUT; fnd1 = 1;
        repeat (TIMEOUT + 1) step();
        chk("t8_late_ack_datasel", bus.datasel_0, 1);
        chk("t8_late_ack_err", err, 0);
        repeat (3) step();

        // No ack: search for TIMEOUT cycles, no pulse, err set and sticky
        bus.req_0 = 1; bus.addr_0 = 11'h055; dly1 = 0;
        scount = 0;
        for (int i = 0; i < TIMEOUT + 1; i++) begin
            step();
            if (bus.search_1) scount++;
        end
        chk("t9_search_cycles", scount, TIMEOUT);
        chk("t9_no_pulse", {bus.datasel_0, bus.inv_1}, 2'b00);
        chk("t9_err_set", err, 1);
        step();
        chk("t9_done0", bus.done_0, 1);
        step(); step();
        bus.req_1 = 1; bus.wr_1 = 0; bus.addr_1 = 11'h077; dly0 = 1; fnd0 = 1;
        repeat (5) step();
        chk("t9_err_sticky", err, 1);
`else
        scount = 0;
        chk("t9_err_tied_low", err, scount);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/snoop_bus_arbiter.md
# snoop_bus_arbiter

Arbitration and sequencing controller for the shared coherence bus between CPU0 and CPU1. It grants the bus to one miss requester at a time and drives the snoop search into the peer cache. From the search result it issues either a cache-to-cache data select (read miss hit) or a peer invalidate (write miss hit), then signals completion. It sits between the two `cpu` instances and the bus datapath, replacing ad-hoc grant logic with a single round-robin FSM.

## Interface
- `ADDR_W`, 11: block address width on the bus.
- `TIMEOUT`, 15: snoop-ack wait limit in cycles; used only with `SNOOP_TIMEOUT_EN`.

- `clk`  in  1  single system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_0`, `req_1`  in  1  miss request from CPU0/CPU1; held until `done_x`.
- `wr_0`, `wr_1`  in  1  1 = write miss, 0 = read miss; qualified by `req_x`.
- `addr_0`, `addr_1`  in  ADDR_W  miss block address; qualified by `req_x`.
- `ack_0`, `ack_1`  in  1  peer search complete from CPU0/CPU1 cache.
- `found_0`, `found_1`  in  1  searched block present/valid in that cache; valid only with `ack_x`.
- `grant_0`, `grant_1`  out  1  bus owned by CPU0/CPU1.
- `bus_addr`  out  ADDR_W  latched owner address while granted, else 0.
- `search_0`, `search_1`  out  1  request CPU0/CPU1 to search its cache for `bus_addr`.
- `datasel_0`, `datasel_1`  out  1  owner takes line from peer cache instead of memory (1-cycle pulse).
- `inv_0`, `inv_1`  out  1  invalidate `bus_addr` in CPU0/CPU1 cache (1-cycle pulse).
- `done_0`, `done_1`  out  1  transaction complete for CPU0/CPU1 (1-cycle pulse).
- `busy`  out  1  FSM not IDLE.
- `err`  out  1  sticky snoop timeout flag.

## Operation
- States: IDLE, SNOOP, RESP, DONE.
- **IDLE**
  - Only one request high: grant it.
  - Both high: grant the CPU named by the round-robin pointer `rr`.
  - Latch owner, `wr` and `addr`, then go to SNOOP.
- **SNOOP**
  - Assert `search_peer`, where peer = the non-owner CPU.
  - Wait for `ack_peer`, then latch `found_peer` and go to RESP.
  - `found_x` without `ack_x` is ignored. The owner's own `ack`/`found` are ignored.
- **RESP** (one cycle)
  - Read miss with found: pulse `datasel_owner`.
  - Write miss with found: pulse `inv_peer`.
  - Not found: no pulse; the owner fetches from memory.
- **DONE** (one cycle)
  - Pulse `done_owner` and set `rr` to the non-owner.
  - Go to IDLE.
- `grant_owner` is high from the first SNOOP cycle through DONE inclusive. At most one grant is high at any time.
- The requester drops `req` on the edge at which `done` is high. In the IDLE cycle right after DONE, the just-served CPU's `req` is masked, which prevents a stale re-grant.
- `addr_x`/`wr_x` changes after grant are ignored; latched values are used.
- `req` dropping mid-transaction does not abort the transaction.
- Reset (any time, including mid-transaction):
  - State → IDLE, `rr` → CPU0.
  - All outputs → 0, `err` → 0.

## Timing
- Cycle 0: `req` seen in IDLE.
- Cycle 1: grant and `search_peer` high, `bus_addr` valid.
- Ack seen in cycle k ≥ 1: RESP in cycle k+1, DONE in cycle k+2.
- Minimum `req` → `done` latency is 3 cycles (ack in the first SNOOP cycle).
- `search_peer` stays high through the ack cycle inclusive and drops the cycle after.
- `busy` = state ≠ IDLE, registered. It is high in cycles 1..k+2.
- Back-to-back transactions: ≥1 IDLE cycle between DONE and the next grant.
- All outputs are registered or decoded from registered state. There are no combinational input→output paths.

## Configuration
- `SNOOP_TIMEOUT_EN` defined:
  - A counter runs in SNOOP.
  - If `ack_peer` has not arrived after `TIMEOUT` SNOOP cycles, the arbiter treats the search as not found, goes to RESP, and sets `err` (sticky until reset).
  - An ack arriving in the same cycle the counter expires is honoured; `err` is not set.
- `SNOOP_TIMEOUT_EN` undefined:
  - SNOOP waits indefinitely.
  - `err` is tied 0 and the counter is not built.

## Test plan
- CPU0 read miss, `addr_0`=0x2A5; CPU1 acks in cycle 2 with found=1 → `grant_0` cycles 1–4, `bus_addr`=0x2A5, `search_1` cycles 1–2, `datasel_0` cycle 3 only, `done_0` cycle 4, no `inv`.
- CPU1 write miss, `addr_1`=0x013; CPU0 acks in cycle 1 with found=1 → `inv_0` cycle 2, `done_1` cycle 3, `datasel_1` stays 0.
- Both CPUs request in the same cycle after reset → CPU0 served first. CPU1 is granted after one IDLE cycle. A third simultaneous pair is served CPU0 first again (alternation).
- Not-found read (ack with found=0) → no `datasel`/`inv` pulse; `done` 2 cycles after the ack.
- Assert `rst_n`=0 in SNOOP with `grant_1` high → all outputs 0 immediately; after release, a CPU0/CPU1 tie grants CPU0.
- With `SNOOP_TIMEOUT_EN`, `TIMEOUT`=15, ack never sent → `search` high 15 cycles, RESP with no pulses, `err`=1, `done` pulses, and `err` stays 1 through subsequent transactions.
